// File: rtl/wb_slave_mux_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_mux_ctrl_if
// Description : Host-side Wishbone and per-slave fan-out signals for
//               wb_slave_mux_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_slave_mux_ctrl_if #(
    parameter int N_SLAVES = 4
);
    logic                     wbs_cyc_i;
    logic                     wbs_stb_i;
    logic                     wbs_we_i;
    logic [3:0]               wbs_sel_i;
    logic [31:0]              wbs_adr_i;
    logic [31:0]              wbs_dat_i;
    logic                     wbs_ack_o;
    logic [31:0]              wbs_dat_o;
    logic [N_SLAVES-1:0]      s_cyc_o;
    logic [N_SLAVES-1:0]      s_stb_o;
    logic                     s_we_o;
    logic [3:0]               s_sel_o;
    logic [31:0]              s_adr_o;
    logic [31:0]              s_dat_o;
    logic [32*N_SLAVES-1:0]   s_dat_i;
    logic [N_SLAVES-1:0]      s_ack_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  s_dat_i, s_ack_i,
        output wbs_ack_o, wbs_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output s_dat_i, s_ack_i,
        input  wbs_ack_o, wbs_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_slave_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_mux_ctrl
// Description : Wishbone slave-port mux: decodes the host address, forwards one
//               access to a sub-project, and always acks (timeout/decode error).
//               Optional status register at slot 4'hF: define WB_MUX_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slave_mux_ctrl #(
    parameter int         N_SLAVES = 4,
    parameter logic [7:0] BASE_HI  = 8'h30,
    parameter int         SLOT_LSB = 20,
    parameter int         TIMEOUT  = 255
) (
    input  wire logic           wb_clk_i,
    input  wire logic           wb_rst_i,
    wb_slave_mux_ctrl_if.slave  bus,
    output logic                timeout_irq_o
);

    localparam int                c_TMR_W       = $clog2(TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST   = c_TMR_W'(TIMEOUT - 1);
    localparam logic [31:0]       c_DAT_DECERR  = 32'hBADA_DD00;
    localparam logic [31:0]       c_DAT_TIMEOUT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state, w_state;
    logic [c_TMR_W-1:0]   r_tmr, w_tmr;
    logic [3:0]           r_slot, w_slot;
    logic [N_SLAVES-1:0]  r_stb, w_stb;
    logic                 r_we, w_we;
    logic [3:0]           r_sel, w_sel;
    logic [31:0]          r_adr, w_adr;
    logic [31:0]          r_wdat, w_wdat;
    logic                 r_ack, w_ack;
    logic [31:0]          r_rdat, w_rdat;
    logic                 r_irq, w_irq;

    logic [3:0]           w_in_slot;
    logic                 w_base_ok;
    logic                 w_hit;
    logic [N_SLAVES-1:0]  w_onehot;
    logic                 w_sel_ack;
    logic [31:0]          w_sel_dat;

`ifdef WB_MUX_STATUS_EN
    logic [15:0]          r_tcnt, w_tcnt;
    logic [3:0]           r_tslot, w_tslot;
    logic                 w_stat_hit;
    logic [31:0]          w_stat_word;

    assign w_stat_hit  = w_base_ok && (w_in_slot == 4'hF);
    assign w_stat_word = {r_tcnt, 4'h0, r_tslot, 7'h0, 1'b0};
`endif

    assign w_in_slot = bus.wbs_adr_i[SLOT_LSB +: 4];
    assign w_base_ok = (bus.wbs_adr_i[31:24] == BASE_HI);
    assign w_hit     = w_base_ok && ({1'b0, w_in_slot} < 5'(N_SLAVES));

    always_comb begin
        w_onehot  = '0;
        w_sel_ack = 1'b0;
        w_sel_dat = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            w_onehot[k] = (w_in_slot == 4'(k));
            if (r_slot == 4'(k)) begin
                w_sel_ack = bus.s_ack_i[k];
                w_sel_dat = bus.s_dat_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_tmr   = r_tmr;
        w_slot  = r_slot;
        w_stb   = r_stb;
        w_we    = r_we;
        w_sel   = r_sel;
        w_adr   = r_adr;
        w_wdat  = r_wdat;
        w_ack   = 1'b0;
        w_rdat  = r_rdat;
        w_irq   = 1'b0;
`ifdef WB_MUX_STATUS_EN
        w_tcnt  = r_tcnt;
        w_tslot = r_tslot;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                    w_adr  = bus.wbs_adr_i;
                    w_wdat = bus.wbs_dat_i;
                    w_we   = bus.wbs_we_i;
                    w_sel  = bus.wbs_sel_i;
                    w_slot = w_in_slot;
                    w_tmr  = '0;
                    if (w_hit) begin
                        w_state = S_FWD;
                        w_stb   = w_onehot;
`ifdef WB_MUX_STATUS_EN
                    end else if (w_stat_hit) begin
                        // Write returns the pre-clear snapshot, then clears.
                        w_state = S_RESP;
                        w_rdat  = w_stat_word;
                        if (bus.wbs_we_i) begin
                            w_tcnt  = '0;
                            w_tslot = '0;
                        end
`endif
                    end else begin
                        w_state = S_RESP;
                        w_rdat  = c_DAT_DECERR;
                    end
                end
            end
            S_FWD: begin
                if (!bus.wbs_cyc_i) begin
                    w_state = S_IDLE;
                    w_stb   = '0;
                end else if (w_sel_ack) begin
                    // Ack beats a simultaneous timer expiry.
                    w_state = S_RESP;
                    w_stb   = '0;
                    w_ack   = 1'b1;
                    w_rdat  = w_sel_dat;
                end else if (r_tmr == c_TMR_LAST) begin
                    w_state = S_RESP;
                    w_stb   = '0;
                    w_ack   = 1'b1;
                    w_rdat  = c_DAT_TIMEOUT;
                    w_irq   = 1'b1;
`ifdef WB_MUX_STATUS_EN
                    if (r_tcnt != 16'hFFFF) begin
                        w_tcnt = r_tcnt + 16'd1;
                    end
                    w_tslot = r_slot;
`endif
                end else begin
                    w_tmr = r_tmr + 1'b1;
                end
            end
            S_RESP: begin
                // Entered with ack clear (decode/status): wait one cycle first.
                if (r_ack) begin
                    w_state = S_IDLE;
                    w_rdat  = '0;
                end else begin
                    w_ack = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_slot  <= '0;
            r_stb   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_ack   <= 1'b0;
            r_rdat  <= '0;
            r_irq   <= 1'b0;
`ifdef WB_MUX_STATUS_EN
            r_tcnt  <= '0;
            r_tslot <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_tmr   <= w_tmr;
            r_slot  <= w_slot;
            r_stb   <= w_stb;
            r_we    <= w_we;
            r_sel   <= w_sel;
            r_adr   <= w_adr;
            r_wdat  <= w_wdat;
            r_ack   <= w_ack;
            r_rdat  <= w_rdat;
            r_irq   <= w_irq;
`ifdef WB_MUX_STATUS_EN
            r_tcnt  <= w_tcnt;
            r_tslot <= w_tslot;
`endif
        end
    end

    assign bus.wbs_ack_o = r_ack;
    assign bus.wbs_dat_o = r_ack ? r_rdat : 32'h0;
    assign bus.s_cyc_o   = r_stb;
    assign bus.s_stb_o   = r_stb;
    assign bus.s_we_o    = r_we;
    assign bus.s_sel_o   = r_sel;
    assign bus.s_adr_o   = r_adr;
    assign bus.s_dat_o   = r_wdat;
    assign timeout_irq_o = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_slave_mux_ctrl
// Description : Randomized self-checking bench for wb_slave_mux_ctrl with a
//               transaction-level expected-waveform model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_slave_mux_ctrl;

    localparam int N    = 4;
    localparam int T    = 8;
    localparam int MAXC = 8192;

    typedef struct packed {
        logic [N-1:0] stb;
        logic         ack;
        logic [31:0]  dat;
        logic         irq;
        logic         chk_bus;
        logic [31:0]  adr;
        logic [31:0]  wdat;
        logic         we;
        logic [3:0]   sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   run = 1'b0;

    exp_t exp_q [MAXC];
    exp_t cmp_e;

    logic [15:0] m_tcnt;
    logic [3:0]  m_tslot;

    int           obs_rel;
    logic [31:0]  obs_dat;
    bit           obs_seen_stb;
    logic [N-1:0] obs_stb;
    logic [31:0]  obs_adr, obs_wdat;
    logic         obs_we;
    logic [3:0]   obs_sel;

    wb_slave_mux_ctrl_if #(.N_SLAVES(N)) bus ();

    wb_slave_mux_ctrl #(
        .N_SLAVES (N),
        .BASE_HI  (8'h30),
        .SLOT_LSB (20),
        .TIMEOUT  (T)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .bus           (bus.slave),
        .timeout_irq_o (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the expected waveform.
    always @(negedge clk) begin
        if (run && cyc < MAXC) begin
            cmp_e = exp_q[cyc];
            chk("s_stb_o", 32'(bus.s_stb_o), 32'(cmp_e.stb));
            chk("s_cyc_o", 32'(bus.s_cyc_o), 32'(cmp_e.stb));
            chk("wbs_ack_o", 32'(bus.wbs_ack_o), 32'(cmp_e.ack));
            chk("wbs_dat_o", bus.wbs_dat_o, cmp_e.dat);
            chk("timeout_irq_o", 32'(irq), 32'(cmp_e.irq));
            if (cmp_e.chk_bus) begin
                chk("s_adr_o", bus.s_adr_o, cmp_e.adr);
                chk("s_dat_o", bus.s_dat_o, cmp_e.wdat);
                chk("s_we_o", 32'(bus.s_we_o), 32'(cmp_e.we));
                chk("s_sel_o", 32'(bus.s_sel_o), 32'(cmp_e.sel));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slaves(input bit valid, input int slot, input bit sel_ack,
                                input logic [31:0] rdat);
        for (int k = 0; k < N; k++) begin
            bus.s_dat_i[32*k +: 32] = $urandom;
            if (valid && k == slot) begin
                bus.s_ack_i[k] = sel_ack;
                if (sel_ack) bus.s_dat_i[32*k +: 32] = rdat;
            end else begin
                bus.s_ack_i[k] = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    // One host access. lat = strobe cycles until the slave acks (> T: never).
    // abort_d >= 0 drops cyc after that many cycles into the strobe phase.
    task automatic txn(input logic [31:0] adr, input logic [31:0] wd, input logic we,
                       input logic [3:0] sel, input int lat, input int abort_d,
                       input logic [31:0] rdat);
        int c0, slot, ack_rel, drop, spend;
        bit base_ok, valid, stat;
        logic [31:0]  exp_d;
        logic [N-1:0] oh;
        c0      = cyc + 1;
        base_ok = (adr[31:24] == 8'h30);
        slot    = int'(adr[23:20]);
        valid   = base_ok && (slot < N);
        stat    = 1'b0;
`ifdef WB_MUX_STATUS_EN
        stat    = base_ok && (slot == 15) && !valid;
`endif
        ack_rel = -1;
        exp_d   = '0;
        spend   = 0;
        oh      = '0;
        obs_rel = -1;
        obs_dat = '0;
        obs_seen_stb = 1'b0;
        if (valid) begin
            oh[slot] = 1'b1;
            if (abort_d >= 0) begin
                spend = abort_d + 1;
            end else if (lat <= T) begin
                spend = lat; ack_rel = lat; exp_d = rdat;
            end else begin
                spend = T; ack_rel = T; exp_d = 32'hDEAD_BEEF;
                exp_q[c0 + T].irq = 1'b1;
                if (m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
                m_tslot = adr[23:20];
            end
            for (int i = 0; i < spend; i++) begin
                exp_q[c0 + i].stb     = oh;
                exp_q[c0 + i].chk_bus = 1'b1;
                exp_q[c0 + i].adr     = adr;
                exp_q[c0 + i].wdat    = wd;
                exp_q[c0 + i].we      = we;
                exp_q[c0 + i].sel     = sel;
            end
        end else begin
            ack_rel = 1;
            if (stat) begin
                exp_d = {m_tcnt, 4'h0, m_tslot, 7'h0, 1'b0};
                if (we) begin m_tcnt = '0; m_tslot = '0; end
            end else begin
                exp_d = 32'hBADA_DD00;
            end
        end
        if (ack_rel >= 0) begin
            exp_q[c0 + ack_rel].ack = 1'b1;
            exp_q[c0 + ack_rel].dat = exp_d;
        end
        drop = (ack_rel >= 0) ? (c0 + ack_rel + 1) : (c0 + abort_d);

        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = wd;
        while (cyc < drop) begin
            drive_slaves(valid, slot, valid && abort_d < 0 && lat <= T && cyc == c0 + lat - 1, rdat);
            tick();
            if (bus.wbs_ack_o && obs_rel < 0) begin
                obs_rel = cyc - c0;
                obs_dat = bus.wbs_dat_o;
            end
            if (!obs_seen_stb && bus.s_stb_o != '0) begin
                obs_seen_stb = 1'b1;
                obs_stb  = bus.s_stb_o;  obs_adr = bus.s_adr_o;
                obs_wdat = bus.s_dat_o;  obs_we  = bus.s_we_o;
                obs_sel  = bus.s_sel_o;
            end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        bus.s_ack_i   = '0;
        repeat ($urandom_range(1, 2)) tick();
    endtask

    initial begin
        #(MAXC * 10 + 100);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, lat, ab, mn;
        logic [7:0]  up;
        logic [3:0]  sl;
        for (int i = 0; i < MAXC; i++) exp_q[i] = '0;
        m_tcnt = '0; m_tslot = '0;
        rst = 1'b1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
        bus.s_dat_i   = '0;   bus.s_ack_i   = '0;
        run = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset asserted during a forwarded access on slot 1.
        c0 = cyc + 1;
        exp_q[c0].stb = 4'b0010; exp_q[c0].chk_bus = 1'b1;
        exp_q[c0].adr = 32'h3010_0000; exp_q[c0].wdat = 32'h0;
        exp_q[c0].we = 1'b0; exp_q[c0].sel = 4'hF;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h3010_0000; bus.wbs_dat_i = 32'h0;
        tick(); tick();
        #1 rst = 1'b1;
        #1;
        chk("rst_stb", 32'(bus.s_stb_o), 32'h0);
        chk("rst_cyc", 32'(bus.s_cyc_o), 32'h0);
        chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        chk("rst_dat", bus.wbs_dat_o, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        m_tcnt = '0; m_tslot = '0;
        tick();
        rst = 1'b0;
        tick();

        // Timeout on slot 3, then ack on the very last cycle, then timeout again.
        txn(32'h3030_0000, 32'h0, 1'b0, 4'hF, T + 5, -1, 32'h0);
        chk("to_lat", 32'(obs_rel), 32'd8);
        chk("to_dat", obs_dat, 32'hDEAD_BEEF);
        txn(32'h3030_0000, 32'h0, 1'b0, 4'hF, T, -1, 32'hCAFE_0001);
        chk("last_lat", 32'(obs_rel), 32'd8);
        chk("last_dat", obs_dat, 32'hCAFE_0001);
        txn(32'h3030_0000, 32'h0, 1'b0, 4'hF, T + 1, -1, 32'h0);
        chk("to2_dat", obs_dat, 32'hDEAD_BEEF);
`ifdef WB_MUX_STATUS_EN
        txn(32'h30F0_0000, 32'h0, 1'b0, 4'hF, 1, -1, 32'h0);
        chk("stat_rd", obs_dat, 32'h0002_0300);
        txn(32'h30F0_0000, 32'h5555_AAAA, 1'b1, 4'hF, 1, -1, 32'h0);
        txn(32'h30F0_0000, 32'h0, 1'b0, 4'hF, 1, -1, 32'h0);
        chk("stat_clr", obs_dat, 32'h0000_0000);
`else
        txn(32'h30F0_0000, 32'h0, 1'b0, 4'hF, 1, -1, 32'h0);
        chk("slotf_dat", obs_dat, 32'hBADA_DD00);
`endif

        // Directed read, write, decode errors and abort.
        txn(32'h3020_0004, 32'h0, 1'b0, 4'hF, 3, -1, 32'h1234_5678);
        chk("rd_lat", 32'(obs_rel), 32'd3);
        chk("rd_dat", obs_dat, 32'h1234_5678);
        chk("rd_stb", 32'(obs_stb), 32'h4);
        chk("rd_adr", obs_adr, 32'h3020_0004);
        txn(32'h3000_0010, 32'hA5A5_0F0F, 1'b1, 4'b0011, 2, -1, 32'h0BAD_F00D);
        chk("wr_lat", 32'(obs_rel), 32'd2);
        chk("wr_we", 32'(obs_we), 32'h1);
        chk("wr_sel", 32'(obs_sel), 32'h3);
        chk("wr_dat", obs_wdat, 32'hA5A5_0F0F);
        txn(32'h4000_0000, 32'h0, 1'b0, 4'hF, 1, -1, 32'h0);
        chk("dec1_lat", 32'(obs_rel), 32'd1);
        chk("dec1_dat", obs_dat, 32'hBADA_DD00);
        txn(32'h3050_0000, 32'h0, 1'b1, 4'hF, 1, -1, 32'h0);
        chk("dec2_lat", 32'(obs_rel), 32'd1);
        chk("dec2_dat", obs_dat, 32'hBADA_DD00);
        txn(32'h3010_0000, 32'h0, 1'b0, 4'hF, 6, 2, 32'h0);
        chk("abort_noack", 32'(obs_rel), 32'hFFFF_FFFF);

        // Randomized mix.
        for (int n = 0; n < 150 && cyc < MAXC - 40; n++) begin
            up  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h30;
            sl  = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, N - 1)) : 4'($urandom);
            lat = $urandom_range(1, T + 2);
            ab  = -1;
            mn  = (lat < T) ? lat : T;
            if (up == 8'h30 && int'(sl) < N && mn >= 2 && $urandom_range(0, 9) == 0)
                ab = $urandom_range(0, mn - 2);
            txn({up, sl, 20'($urandom)}, $urandom, 1'($urandom), 4'($urandom), lat, ab, $urandom);
        end

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
